// File: rtl/systolic_matmul_pkg.sv
// systolic_matmul_pkg: shared FSM state type, sizing helpers and default localparams
package systolic_matmul_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;
   function automatic int idx_w(input int size);
      return $clog2(size * size);
   endfunction
   function automatic int kcnt_w(input int max_k);
      return $clog2(max_k + 1);
   endfunction
   function automatic int drain_cyc(input int size);
      return 3 * size - 2;
   endfunction
   localparam int IDX_W = idx_w(4);
   localparam int KCNT_W = kcnt_w(255);
   localparam int DRAIN_CYC = drain_cyc(4);
endpackage

// File: rtl/systolic_matmul_pe.sv
// pe_cell: one systolic MAC node, forwards a right / b down and accumulates a*b
// ports: clk, reset (async active-low), clr (zero all state), en (step),
//        sgn (two's-complement product), a_in/b_in, a_out/b_out, acc
module pe_cell #(
   parameter int DATA_W = 8,
   parameter int ACC_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic              sgn,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ACC_W-1:0]  acc
);
   logic [2*DATA_W-1:0] ax, bx, p;
   logic [ACC_W-1:0] prod;
   // extending before a 2W-bit multiply gives the right low bits for both modes
   assign ax = sgn ? {{DATA_W{a_in[DATA_W-1]}}, a_in} : {{DATA_W{1'b0}}, a_in};
   assign bx = sgn ? {{DATA_W{b_in[DATA_W-1]}}, b_in} : {{DATA_W{1'b0}}, b_in};
   assign p = ax * bx;
   assign prod = sgn ? ACC_W'($signed(p)) : ACC_W'(p);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         a_out <= '0;
         b_out <= '0;
         acc <= '0;
      end else if (clr) begin
         a_out <= '0;
         b_out <= '0;
         acc <= '0;
      end else if (en) begin
         a_out <= a_in;
         b_out <= b_in;
         acc <= acc + prod;
      end
endmodule

// File: rtl/systolic_matmul.sv
// systolic_matmul: output-stationary SIZE x SIZE systolic array computing C = A * B
// ports: clk, reset (async active-low), start/k_len/signed_mode (job request),
//        in_valid/in_ready/a_col/b_row (operand beats), out_valid/out_ready/
//        out_data/out_idx/out_last (row-major result stream), busy
module systolic_matmul
   import systolic_matmul_pkg::*;
#(
   parameter int SIZE = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W = 32,
   parameter int MAX_K = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [$clog2(MAX_K+1)-1:0]     k_len,
   input  logic                           signed_mode,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [SIZE-1:0][DATA_W-1:0]    a_col,
   input  logic [SIZE-1:0][DATA_W-1:0]    b_row,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ACC_W-1:0]               out_data,
   output logic [$clog2(SIZE*SIZE)-1:0]   out_idx,
   output logic                           out_last,
   output logic                           busy
);
   localparam int KW = kcnt_w(MAX_K);
   localparam int IW = idx_w(SIZE);
   localparam int DC = drain_cyc(SIZE);
   localparam int DW = $clog2(DC);
   state_t state, nxt;
   logic [KW-1:0] kreg, kcnt;
   logic [DW-1:0] dcnt;
   logic [IW-1:0] oidx;
   logic sgn, clr, en, xfer, olast;
   logic [DATA_W-1:0] a_h [SIZE][SIZE+1];
   logic [DATA_W-1:0] b_v [SIZE+1][SIZE];
   logic [ACC_W-1:0] acc [SIZE*SIZE];
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      in_ready = 1'b0;
      out_valid = 1'b0;
      clr = 1'b0;
      en = 1'b0;
      case (state)
         IDLE: if (start) begin
            clr = 1'b1;
            nxt = (k_len == '0) ? OUT : LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            en = 1'b1;
            if (in_valid && kcnt == kreg - KW'(1)) nxt = DRAIN;
         end
         DRAIN: begin
            en = 1'b1;
            if (dcnt == DW'(DC - 1)) nxt = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready && olast) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end
   assign xfer = in_valid & in_ready;
   assign olast = oidx == IW'(SIZE * SIZE - 1);
   assign out_last = out_valid & olast;
   assign out_idx = oidx;
   assign out_data = out_valid ? acc[oidx] : '0;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         kreg <= '0;
         sgn <= 1'b0;
         kcnt <= '0;
         dcnt <= '0;
         oidx <= '0;
      end else begin
         if (clr) begin
            kreg <= k_len;
            sgn <= signed_mode;
         end
         kcnt <= (state == LOAD) ? kcnt + KW'(xfer) : '0;
         dcnt <= (state == DRAIN) ? dcnt + DW'(1) : '0;
         if (out_valid && out_ready) oidx <= olast ? '0 : oidx + IW'(1);
      end
   // row i of A and column i of B get i register stages; idle cycles feed zeros
   for (genvar i = 0; i < SIZE; i++) begin : g_skew
      if (i == 0) begin : g_d0
         assign a_h[0][0] = xfer ? a_col[0] : '0;
         assign b_v[0][0] = xfer ? b_row[0] : '0;
      end else begin : g_dn
         logic [DATA_W-1:0] da [i];
         logic [DATA_W-1:0] db [i];
         always_ff @(posedge clk or negedge reset)
            if (!reset || clr) begin
               for (int d = 0; d < i; d++) begin
                  da[d] <= '0;
                  db[d] <= '0;
               end
            end else begin
               da[0] <= xfer ? a_col[i] : '0;
               db[0] <= xfer ? b_row[i] : '0;
               for (int d = 1; d < i; d++) begin
                  da[d] <= da[d-1];
                  db[d] <= db[d-1];
               end
            end
         assign a_h[i][0] = da[i-1];
         assign b_v[0][i] = db[i-1];
      end
   end
   for (genvar i = 0; i < SIZE; i++) begin : g_row
      for (genvar j = 0; j < SIZE; j++) begin : g_col
         pe_cell #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
            .clk(clk),
            .reset(reset),
            .clr(clr),
            .en(en),
            .sgn(sgn),
            .a_in(a_h[i][j]),
            .b_in(b_v[i][j]),
            .a_out(a_h[i][j+1]),
            .b_out(b_v[i+1][j]),
            .acc(acc[i*SIZE+j])
         );
      end
   end
endmodule

// File: tb/tb_systolic_matmul.sv
// tb_systolic_matmul: directed jobs with a queue scoreboard checked by an output monitor
module tb_systolic_matmul;
   logic clk, reset, start, signed_mode, in_valid, in_ready;
   logic out_valid, out_ready, out_last, busy;
   logic [7:0] k_len;
   logic [3:0][7:0] a_col, b_row;
   logic [31:0] out_data;
   logic [3:0] out_idx;
   typedef struct {
      logic [3:0] idx;
      logic [31:0] data;
      logic last;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int checks = 0, errors = 0;
   bit saw_ready = 0, stall_en = 0, have_hold = 0;
   int stall_n = 0;
   logic [3:0] h_idx;
   logic [31:0] h_data;
   systolic_matmul dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len),
      .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
      .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   initial begin
      out_ready = 1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_en && out_valid && out_idx == 4'd3 && stall_n < 5) begin
            out_ready = 0;
            stall_n++;
         end else out_ready = 1;
      end
   end
   always @(negedge clk) begin
      if (in_ready) saw_ready = 1;
      if (out_valid && out_ready) begin
         have_hold = 0;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out idx=%0d data=%0d", out_idx, out_data);
         end else begin
            e = q.pop_front();
            if (out_idx !== e.idx || out_data !== e.data || out_last !== e.last) begin
               errors++;
               $display("FAIL out got idx=%0d data=%0d last=%0b want idx=%0d data=%0d last=%0b",
                        out_idx, out_data, out_last, e.idx, e.data, e.last);
            end
         end
      end else if (out_valid) begin
         if (have_hold) begin
            checks++;
            if (out_idx !== h_idx || out_data !== h_data) begin
               errors++;
               $display("FAIL stall_hold got idx=%0d data=%0d want idx=%0d data=%0d",
                        out_idx, out_data, h_idx, h_data);
            end
         end else begin
            h_idx = out_idx;
            h_data = out_data;
            have_hold = 1;
         end
      end else have_hold = 0;
   end
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask
   task automatic check_zero(input string name);
      check(name, {in_ready, out_valid, out_last, busy, out_idx, out_data}, 64'd0);
   endtask
   task automatic job(input bit ff, input int k, input bit sg, input bit tog,
                      input bit hold, input bit abort, input logic [31:0] ed,
                      input logic [31:0] eo);
      int n, beat;
      bit tr;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) check("wait_idle", busy, 0);
      start = 1;
      k_len = 8'(k);
      signed_mode = sg;
      if (!abort)
         for (int i = 0; i < 16; i++)
            q.push_back('{idx: 4'(i), data: (i / 4 == i % 4) ? ed : eo, last: i == 15});
      @(posedge clk);
      #1;
      start = 0;
      k_len = 8'd7;
      signed_mode = !sg;
      beat = 0;
      n = 0;
      while (beat < k && n < 100) begin
         in_valid = tog ? (n % 2 == 0) : 1'b1;
         for (int i = 0; i < 4; i++) begin
            a_col[i] = ff ? 8'hFF : ((i == beat) ? 8'd1 : 8'd0);
            b_row[i] = ff ? 8'hFF : ((i == beat) ? 8'd1 : 8'd0);
         end
         tr = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (tr) beat++;
         n++;
      end
      if (beat < k) check("beats_accepted", beat, k);
      in_valid = 0;
      a_col = '0;
      b_row = '0;
      if (abort) begin
         repeat (3) @(posedge clk);
         #1;
         reset = 0;
         #1;
         check_zero("abort_outputs");
         @(posedge clk);
         #1;
         reset = 1;
         check_zero("abort_release");
         return;
      end
      if (hold) start = 1;
      n = 0;
      while (!(out_valid && out_ready && out_last) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("last_timeout", n, 0);
      @(posedge clk);
      #1;
      check("busy_after_last", busy, 0);
      start = 0;
   endtask
   initial begin
      reset = 0;
      start = 0;
      k_len = 0;
      signed_mode = 0;
      in_valid = 0;
      a_col = '0;
      b_row = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      reset = 1;
      @(posedge clk);
      #1;
      check("idle_no_start", busy, 0);
      job(0, 4, 0, 0, 0, 0, 32'd1, 32'd0);
      job(1, 4, 1, 0, 0, 0, 32'd4, 32'd4);
      job(1, 4, 0, 0, 0, 0, 32'd260100, 32'd260100);
      job(0, 4, 0, 1, 0, 0, 32'd1, 32'd0);
      stall_en = 1;
      saw_ready = 0;
      job(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
      check("k0_no_in_ready", saw_ready, 0);
      check("k0_stall_cycles", stall_n, 5);
      stall_en = 0;
      job(0, 4, 0, 0, 0, 1, 32'd0, 32'd0);
      job(0, 4, 0, 0, 0, 0, 32'd1, 32'd0);
      job(0, 4, 0, 0, 1, 0, 32'd1, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_held_start", busy, 0);
      check("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
